// File: rtl/fi_pkg.sv
// Shared types and fault-point decode for the fault-injectable counter bank.
// Pure combinational helpers: no latency, no backpressure.
package fi_pkg;

    typedef enum logic [1:0] {
        FK_NONE   = 2'd0,
        FK_ENABLE = 2'd1,
        FK_DIR    = 2'd2,
        FK_BIT    = 2'd3
    } fault_kind_e;

    typedef struct packed {
        logic [15:0] chan;
        fault_kind_e kind;
        logic [15:0] bit_idx;
    } fp_dec_t;

    function automatic int unsigned fi_stride(input int unsigned width);
        return width + 2;
    endfunction

    function automatic int unsigned fi_num_fp(input int unsigned channels, input int unsigned width);
        return channels * fi_stride(width);
    endfunction

    // Fault points are 1-based; 0 and anything past the last channel decode to FK_NONE.
    function automatic fp_dec_t fi_decode(input int unsigned fp, input int unsigned channels,
                                          input int unsigned width);
        fp_dec_t     d;
        int unsigned idx;
        int unsigned off;
        d.chan    = '0;
        d.kind    = FK_NONE;
        d.bit_idx = '0;
        idx       = 0;
        off       = 0;
        if (fp != 0 && fp <= fi_num_fp(channels, width)) begin
            idx    = fp - 1;
            off    = idx % fi_stride(width);
            d.chan = 16'(idx / fi_stride(width));
            if (off == 0) begin
                d.kind = FK_ENABLE;
            end else if (off == 1) begin
                d.kind = FK_DIR;
            end else begin
                d.kind    = FK_BIT;
                d.bit_idx = 16'(off - 2);
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/fi_counter_channel.sv
// One up/down counter with enable/direction/count-bit fault hooks; wrap or saturate.
// Latency: count and wrap registered, one edge after inputs. Backpressure: none.
module fi_counter_channel
    import fi_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             clear,
    input  logic [1:0]       fk_kind,
    input  logic [15:0]      fk_bit,
    output logic [WIDTH-1:0] count,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             eff_en;
    logic             eff_up;
    logic             at_limit;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] mask;

    always_comb begin
        eff_en   = enable ^ (fk_kind == FK_ENABLE);
        eff_up   = up ^ (fk_kind == FK_DIR);
        at_limit = 1'b0;
        step_val = count_q;
        if (clear) begin
            step_val = '0;
        end else if (eff_en) begin
            if (eff_up) begin
                at_limit = (count_q == '1);
                step_val = (at_limit && SATURATE != 0) ? count_q : count_q + WIDTH'(1);
            end else begin
                at_limit = (count_q == '0);
                step_val = (at_limit && SATURATE != 0) ? count_q : count_q - WIDTH'(1);
            end
        end
        // The bit flip lands on top of whatever action won, clear included.
        mask    = (fk_kind == FK_BIT) ? (WIDTH'(1) << fk_bit) : '0;
        count_d = step_val ^ mask;
        wrap_d  = at_limit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;

endmodule

// File: rtl/fi_counter_bank.sv
// Bank of fault-injectable counters: decodes fp, gates one-shot faults, counts hits.
// Latency: all outputs registered, one edge. Backpressure: none.
module fi_counter_bank
    import fi_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int FP_WIDTH = 8,
    parameter int SATURATE = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [CHANNELS-1:0]       up,
    input  logic [CHANNELS-1:0]       clear,
    input  logic [FP_WIDTH-1:0]       fp,
    input  logic                      fi_persistent,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       wrap,
    output logic                      fi_active,
    output logic [15:0]               fi_hits
);

    localparam int NUM_FP = int'(fi_num_fp(CHANNELS, WIDTH));

    if ((64'd1 << FP_WIDTH) <= 64'(NUM_FP)) begin : g_fp_width_check
        $error("fi_counter_bank: FP_WIDTH too narrow to address every fault point");
    end

    logic [FP_WIDTH-1:0] fp_q, fp_d;
    logic                fi_active_q, fi_active_d;
    logic [15:0]         fi_hits_q, fi_hits_d;
    fp_dec_t             dec;
    logic                fire;
    logic [1:0]          ch_kind [CHANNELS];

    always_comb begin
        dec  = fi_decode(32'(fp), CHANNELS, WIDTH);
        // One-shot faults only fire on the edge where fp takes a new valid value.
        fire = (dec.kind != FK_NONE) && (fi_persistent || (fp != fp_q));
        for (int c = 0; c < CHANNELS; c++) begin
            ch_kind[c] = (fire && dec.chan == 16'(c)) ? dec.kind : FK_NONE;
        end
        fp_d        = fp;
        fi_active_d = fire;
        fi_hits_d   = fi_hits_q;
        if (fire && fi_hits_q != 16'hFFFF) begin
            fi_hits_d = fi_hits_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fp_q        <= '0;
            fi_active_q <= 1'b0;
            fi_hits_q   <= '0;
        end else begin
            fp_q        <= fp_d;
            fi_active_q <= fi_active_d;
            fi_hits_q   <= fi_hits_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        fi_counter_channel #(
            .WIDTH    (WIDTH),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .enable  (enable[c]),
            .up      (up[c]),
            .clear   (clear[c]),
            .fk_kind (ch_kind[c]),
            .fk_bit  (dec.bit_idx),
            .count   (count[c*WIDTH +: WIDTH]),
            .wrap    (wrap[c])
        );
    end

    assign fi_active = fi_active_q;
    assign fi_hits   = fi_hits_q;

endmodule

// File: tb/tb_fi_counter_bank.sv
// Directed bench for fi_counter_bank: a wrapping and a saturating instance share stimulus.
module tb_fi_counter_bank;

    logic        clk;
    logic        reset;
    logic [3:0]  enable;
    logic [3:0]  up;
    logic [3:0]  clear;
    logic [7:0]  fp;
    logic        fi_persistent;
    logic [31:0] count;
    logic [3:0]  wrap;
    logic        fi_active;
    logic [15:0] fi_hits;
    logic [31:0] s_count;
    logic [3:0]  s_wrap;
    logic        s_fi_active;
    logic [15:0] s_fi_hits;

    int vectors;
    int miscompares;

    fi_counter_bank #(.CHANNELS(4), .WIDTH(8), .FP_WIDTH(8), .SATURATE(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .fp(fp),
        .fi_persistent(fi_persistent), .count(count), .wrap(wrap),
        .fi_active(fi_active), .fi_hits(fi_hits)
    );

    fi_counter_bank #(.CHANNELS(4), .WIDTH(8), .FP_WIDTH(8), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .enable(enable), .up(up), .clear(clear), .fp(fp),
        .fi_persistent(fi_persistent), .count(s_count), .wrap(s_wrap),
        .fi_active(s_fi_active), .fi_hits(s_fi_hits)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses [4];
        int last_edge [4];
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b1;
        enable        = '0;
        up            = '0;
        clear         = '0;
        fp            = '0;
        fi_persistent = 1'b0;
        #2;
        chk("reset_count", count, 32'h0);
        chk("reset_wrap", {28'h0, wrap}, 32'h0);
        chk("reset_active", {31'h0, fi_active}, 32'h0);
        chk("reset_hits", {16'h0, fi_hits}, 32'h0);

        // Wrap, no fault: 300 edges from 0 -> 300 mod 256 = 44, one wrap after edge 256.
        enable = 4'hF;
        up     = 4'hF;
        #1 reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            pulses[c]    = 0;
            last_edge[c] = 0;
        end
        for (int e = 1; e <= 300; e++) begin
            step();
            for (int c = 0; c < 4; c++) begin
                if (wrap[c]) begin
                    pulses[c]++;
                    last_edge[c] = e;
                end
            end
        end
        chk("wrap_count", count, 32'h2C2C2C2C);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("wrap_pulses_ch%0d", c), 32'(pulses[c]), 32'd1);
            chk($sformatf("wrap_edge_ch%0d", c), 32'(last_edge[c]), 32'd256);
        end
        chk("wrap_hits", {16'h0, fi_hits}, 32'h0);

        // Persistent enable fault on ch0 with all enables low.
        enable = 4'h0;
        clear  = 4'hF;
        step();
        chk("clear_all", count, 32'h0);
        clear         = 4'h0;
        fp            = 8'd1;
        fi_persistent = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk($sformatf("pers_active_%0d", i), {31'h0, fi_active}, 32'h1);
        end
        chk("pers_count", count, 32'h00000005);
        chk("pers_hits", {16'h0, fi_hits}, 32'd5);
        fp = 8'd0;
        step();
        chk("pers_off_active", {31'h0, fi_active}, 32'h0);
        chk("pers_off_hits", {16'h0, fi_hits}, 32'd5);

        // One-shot bit fault: fp 20 = ch1 offset 9 = bit 7.
        clear = 4'hF;
        step();
        clear  = 4'h0;
        enable = 4'b0010;
        up     = 4'hF;
        step();
        step();
        step();
        chk("oneshot_pre", count, 32'h00000300);
        fp            = 8'd20;
        fi_persistent = 1'b0;
        step();
        chk("oneshot_hit", count, 32'h00008400);
        chk("oneshot_active", {31'h0, fi_active}, 32'h1);
        chk("oneshot_hits", {16'h0, fi_hits}, 32'd6);
        step();
        chk("oneshot_after", count, 32'h00008500);
        chk("oneshot_after_active", {31'h0, fi_active}, 32'h0);
        chk("oneshot_after_hits", {16'h0, fi_hits}, 32'd6);

        // Down-count at ch2 from 1: wrapping vs saturating instance.
        fp     = 8'd0;
        clear  = 4'hF;
        step();
        clear  = 4'h0;
        enable = 4'b0100;
        up     = 4'hF;
        step();
        chk("sat_pre", s_count, 32'h00010000);
        up = 4'b1011;
        step();
        chk("down1_wrapdut", count, 32'h00000000);
        chk("down1_wrap", {28'h0, wrap}, 32'h0);
        chk("down1_satdut", s_count, 32'h00000000);
        chk("down1_satwrap", {28'h0, s_wrap}, 32'h0);
        step();
        chk("down2_wrapdut", count, 32'h00FF0000);
        chk("down2_wrap", {28'h0, wrap}, 32'h4);
        chk("down2_satdut", s_count, 32'h00000000);
        chk("down2_satwrap", {28'h0, s_wrap}, 32'h4);
        enable = 4'h0;
        step();
        chk("down3_satwrap", {28'h0, s_wrap}, 32'h0);

        // Reset between edges, then release with one-shot fp 3 (ch0 bit0).
        enable = 4'hF;
        up     = 4'hF;
        step();
        step();
        reset = 1'b1;
        #2;
        chk("midreset_count", count, 32'h0);
        chk("midreset_wrap", {28'h0, wrap}, 32'h0);
        chk("midreset_active", {31'h0, fi_active}, 32'h0);
        chk("midreset_hits", {16'h0, fi_hits}, 32'h0);
        enable        = 4'h0;
        fp            = 8'd3;
        fi_persistent = 1'b0;
        #1 reset = 1'b0;
        step();
        chk("release_count", count, 32'h00000001);
        chk("release_active", {31'h0, fi_active}, 32'h1);
        chk("release_hits", {16'h0, fi_hits}, 32'd1);
        step();
        step();
        chk("release_hold_count", count, 32'h00000001);
        chk("release_hold_active", {31'h0, fi_active}, 32'h0);
        chk("release_hold_hits", {16'h0, fi_hits}, 32'd1);

        // Invalid fp 41 persistent: plain counting.
        enable        = 4'hF;
        up            = 4'hF;
        fp            = 8'd41;
        fi_persistent = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("invalid_count", count, 32'h0A0A0A0B);
        chk("invalid_hits", {16'h0, fi_hits}, 32'd1);
        chk("invalid_active", {31'h0, fi_active}, 32'h0);

        // Last valid point 40 = ch3 bit7.
        fp = 8'd40;
        step();
        chk("fp40_count", count, 32'h8B0B0B0C);
        chk("fp40_hits", {16'h0, fi_hits}, 32'd2);

        // fp 2 = ch0 direction flip while counting up.
        fp = 8'd2;
        step();
        chk("dir_count", count, 32'h8C0C0C0B);
        chk("dir_hits", {16'h0, fi_hits}, 32'd3);
        chk("dir_active", {31'h0, fi_active}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fi_counter_bank.md
# fi_counter_bank

Parametrised bank of up/down counters with built-in single-bit fault injection, used as a fault-campaign target in the injection test infrastructure. A single fault-point index `fp` selects one injectable bit across all channels: a channel's enable, its direction, or one bit of its count register. Faults are applied either persistently, while `fp` selects the bit, or as a one-shot transient. The block counts how many fault injections actually occurred, so campaigns can confirm hits.

## Interface
- `CHANNELS`, 4: number of independent counters.
- `WIDTH`, 8: counter width in bits.
- `FP_WIDTH`, 8: width of `fp`. Must satisfy 2^FP_WIDTH > NUM_FP (elaboration check).
- `SATURATE`, 0: 0 = counters wrap; 1 = counters saturate at 0 and 2^WIDTH-1.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `enable` in CHANNELS: per-channel count enable.
- `up` in CHANNELS: per-channel direction; 1 = increment, 0 = decrement.
- `clear` in CHANNELS: per-channel synchronous clear to 0.
- `fp` in FP_WIDTH: fault point; 0 = no fault.
- `fi_persistent` in 1: 1 = persistent fault mode; 0 = one-shot fault mode.
- `count` out CHANNELS*WIDTH: counter values, packed; channel c occupies [c*WIDTH +: WIDTH].
- `wrap` out CHANNELS: one-cycle limit pulse per channel.
- `fi_active` out 1: a fault was applied on the previous edge.
- `fi_hits` out 16: saturating count of applied faults.

## Operation
- Fault map: each channel has STRIDE = WIDTH+2 points, with base(c) = 1 + c*STRIDE.
  - base+0 inverts the effective enable.
  - base+1 inverts the effective direction.
  - base+2+k XORs bit k into the value written to `count[c]`.
- NUM_FP = CHANNELS*STRIDE. `fp` = 0 or `fp` > NUM_FP is invalid and injects nothing.
- Persistent mode: the fault applies on every edge where `fp` is valid.
- One-shot mode: the fault applies only on an edge where `fp` is valid and `fp` differs from `fp_q`. `fp_q` is a register loaded with `fp` on every edge and reset to 0.
- Per-channel next value, before the bit mask:
  - if `clear`, 0;
  - else if the effective enable is 1, ±1 in the effective direction;
  - else hold.
- Count-bit fault: the stored value is next ^ (1<<k). The mask also applies over a clear.
- Arithmetic is modulo 2^WIDTH. With SATURATE=1, a step past a limit holds the counter at that limit.
- `wrap[c]` is registered and high for one cycle after any edge where the effective step crossed a limit:
  - wrapping: max→0 going up, or 0→max going down;
  - saturating: a step attempted at the limit.
  - It is evaluated before the bit mask and is suppressed when `clear` is active.
- `fi_hits` increments on every edge where a fault was applied, including faults with no visible effect (for example, enable inverted on a cleared channel). It saturates at 0xFFFF.
- `fi_persistent` is sampled combinationally each cycle. Switching modes mid-run takes effect on the next edge.

## Timing
- Reset: `count`, `wrap`, `fi_active`, `fi_hits` and `fp_q` go to 0 immediately, without waiting for a clock edge.
- Latency: all outputs are registered, one edge after the inputs.
- Priority: `reset` > `clear` > count step. The fault is applied on top of the winning action.
- A valid `fp` held through reset release fires once in one-shot mode on the first edge after release, because `fp_q` is 0 after reset.
- Simultaneous edges: all channels update independently on the same edge; only the targeted channel is faulted.

## Structure
- Package `fi_pkg` holds:
  - the function computing STRIDE and NUM_FP;
  - the fault-kind enum (FK_NONE, FK_ENABLE, FK_DIR, FK_BIT);
  - a decode function `fp` → {channel, kind, bit}.
- Sub-module `fi_counter_channel` is instantiated CHANNELS times. Each instance takes its decoded fault kind and bit; `fi_counter_bank` performs the decode, the one-shot logic and `fi_hits`.

## Test plan
All scenarios use CHANNELS=4, WIDTH=8 (STRIDE=10, NUM_FP=40) unless stated otherwise.
- **Wrap, no fault.** Reset; all channels enabled, `up`=1, `fp`=0, 300 cycles. Expect every `count` = 44, `wrap` pulsed once per channel after edge 256, `fi_hits` = 0.
- **Persistent enable fault.** `fp`=1, `fi_persistent`=1, all `enable`=0, 5 cycles. Expect ch0 = 5, ch1..3 = 0, `fi_hits` = 5, `fi_active` high throughout.
- **One-shot bit fault.** ch1 counting up at 3; `fp` changes to 20 (ch1 bit7), `fi_persistent`=0. Expect ch1 0x84, then 0x85 on the next edge; `fi_hits` = 1.
- **Saturate.** SATURATE=1; ch2 at 1, `up`=0, enabled 2 cycles. Expect 0 then 0, with `wrap[2]` pulsed after the second edge only.
- **Reset mid-operation.** Assert `reset` between clock edges. Expect all outputs 0 before the next edge. Then release with `fp`=3 in one-shot mode: expect exactly one flip of ch0 bit0, and `fi_hits` = 1.
- **Invalid `fp`.** `fp`=41 persistent for 10 cycles. Expect no deviation from fault-free counts and `fi_hits` unchanged.
